// File: rtl/led_pattern_monitor.sv
// Receive-side checker for the 4-LED pattern bus.
// It samples the LED code on every valid strobe and classifies each step as
// forward, reverse, repeat or illegal. It keeps step and error counters and
// reports lock once enough consecutive legal transitions have been seen.
// Every output is registered, so results appear one cycle after the sample.
module led_pattern_monitor #(
   parameter int NB_LEDS  = 4,
   parameter int NB_COUNT = 16,
   parameter int LOCK_LEN = 3
) (
   input  logic                clock,
   input  logic                i_reset,
   input  logic                i_valid,
   input  logic [NB_LEDS-1:0]  i_led,
   output logic                o_locked,
   output logic                o_direction,
   output logic                o_dir_change,
   output logic                o_error,
   output logic [NB_COUNT-1:0] o_step_count,
   output logic [NB_COUNT-1:0] o_err_count
);

   // The only legal codes are those emitted by the shift-register generator.
   localparam logic [NB_LEDS-1:0] CodeA = 4'b0000;
   localparam logic [NB_LEDS-1:0] CodeB = 4'b1001;
   localparam logic [NB_LEDS-1:0] CodeC = 4'b0110;

   // The run counter only has to reach LOCK_LEN, which never exceeds 15.
   localparam logic [3:0] LockRun = 4'(LOCK_LEN);
   localparam logic [3:0] RunOne  = 4'd1;

   localparam logic [NB_COUNT-1:0] CountOne = NB_COUNT'(1);
   localparam logic [NB_COUNT-1:0] CountMax = {NB_COUNT{1'b1}};

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      PRIMED = 2'd1,
      LOCKED = 2'd2
   } MonitorState;

   MonitorState         state_q,      state_d;
   logic [NB_LEDS-1:0]  prevCode_q,   prevCode_d;
   logic [3:0]          run_q,        run_d;
   logic                locked_q,     locked_d;
   logic                direction_q,  direction_d;
   logic                dirChange_q,  dirChange_d;
   logic                error_q,      error_d;
   logic [NB_COUNT-1:0] stepCount_q,  stepCount_d;
   logic [NB_COUNT-1:0] errCount_q,   errCount_d;

   logic curLegal;
   logic isRepeat;
   logic isStep;
   logic stepForward;
   logic stepDirection;
   logic [3:0] runNext;
   logic [NB_COUNT-1:0] errCountNext;

   // Classify the current sample against the stored previous code. With only
   // three legal codes, any legal change is either a forward or reverse step.
   always_comb begin
      curLegal      = (i_led == CodeA) || (i_led == CodeB) || (i_led == CodeC);
      isRepeat      = curLegal && (i_led == prevCode_q);
      isStep        = curLegal && (i_led != prevCode_q);
      stepForward   = ((prevCode_q == CodeA) && (i_led == CodeB)) ||
                      ((prevCode_q == CodeB) && (i_led == CodeC)) ||
                      ((prevCode_q == CodeC) && (i_led == CodeA));
      stepDirection = ~stepForward;
      runNext       = (run_q >= LockRun) ? LockRun : (run_q + RunOne);
      errCountNext  = (errCount_q == CountMax) ? CountMax : (errCount_q + CountOne);
   end

   // Next-state and registered-output logic for the EMPTY/PRIMED/LOCKED tracker.
   always_comb begin
      state_d     = state_q;
      prevCode_d  = prevCode_q;
      run_d       = run_q;
      direction_d = direction_q;
      dirChange_d = 1'b0;
      error_d     = 1'b0;
      stepCount_d = stepCount_q;
      errCount_d  = errCount_q;

      if (i_valid) begin
         case (state_q)
            EMPTY: begin
               if (curLegal) begin
                  prevCode_d = i_led;
                  state_d    = PRIMED;
               end else begin
                  error_d    = 1'b1;
                  errCount_d = errCountNext;
               end
            end
            PRIMED, LOCKED: begin
               if (isStep) begin
                  direction_d = stepDirection;
                  dirChange_d = (state_q == LOCKED) && (stepDirection != direction_q);
                  stepCount_d = stepCount_q + CountOne;
                  prevCode_d  = i_led;
                  run_d       = runNext;
                  if (runNext == LockRun) begin
                     state_d = LOCKED;
                  end
               end else if (isRepeat) begin
                  error_d    = 1'b1;
                  errCount_d = errCountNext;
                  run_d      = 4'd0;
                  state_d    = PRIMED;
               end else begin
                  error_d    = 1'b1;
                  errCount_d = errCountNext;
                  run_d      = 4'd0;
                  prevCode_d = CodeA;
                  state_d    = EMPTY;
               end
            end
            default: begin
               run_d      = 4'd0;
               prevCode_d = CodeA;
               state_d    = EMPTY;
            end
         endcase
      end else if ((state_q != EMPTY) && (state_q != PRIMED) && (state_q != LOCKED)) begin
         run_d      = 4'd0;
         prevCode_d = CodeA;
         state_d    = EMPTY;
      end

      locked_d = (state_d == LOCKED);
   end

   // State and output registers; reset takes priority over any sample.
   always_ff @(posedge clock) begin
      if (i_reset) begin
         state_q     <= EMPTY;
         prevCode_q  <= CodeA;
         run_q       <= 4'd0;
         locked_q    <= 1'b0;
         direction_q <= 1'b0;
         dirChange_q <= 1'b0;
         error_q     <= 1'b0;
         stepCount_q <= '0;
         errCount_q  <= '0;
      end else begin
         state_q     <= state_d;
         prevCode_q  <= prevCode_d;
         run_q       <= run_d;
         locked_q    <= locked_d;
         direction_q <= direction_d;
         dirChange_q <= dirChange_d;
         error_q     <= error_d;
         stepCount_q <= stepCount_d;
         errCount_q  <= errCount_d;
      end
   end

   assign o_locked     = locked_q;
   assign o_direction  = direction_q;
   assign o_dir_change = dirChange_q;
   assign o_error      = error_q;
   assign o_step_count = stepCount_q;
   assign o_err_count  = errCount_q;

endmodule

// File: tb/tb_led_pattern_monitor.sv
// Testbench for led_pattern_monitor: a directed vector table, a narrow-counter
// instance for wrap/saturation, and random traffic against a reference model.
module tb_led_pattern_monitor;

   localparam logic [3:0] CA = 4'b0000;
   localparam logic [3:0] CB = 4'b1001;
   localparam logic [3:0] CC = 4'b0110;
   localparam logic [3:0] CF = 4'b1111;
   localparam int LOCK_LEN = 3;

   logic        clock = 1'b0;
   logic        mReset = 1'b1;
   logic        mValid = 1'b0;
   logic [3:0]  mLed = 4'b0000;
   logic        mLocked, mDir, mDirChange, mError;
   logic [15:0] mSteps, mErrs;

   logic        sReset = 1'b1;
   logic        sValid = 1'b0;
   logic [3:0]  sLed = 4'b0000;
   logic        sLocked, sDir, sDirChange, sError;
   logic [3:0]  sSteps, sErrs;

   int checks = 0;
   int passed = 0;

   led_pattern_monitor #(.NB_LEDS(4), .NB_COUNT(16), .LOCK_LEN(LOCK_LEN)) dutMain (
      .clock(clock), .i_reset(mReset), .i_valid(mValid), .i_led(mLed),
      .o_locked(mLocked), .o_direction(mDir), .o_dir_change(mDirChange),
      .o_error(mError), .o_step_count(mSteps), .o_err_count(mErrs)
   );

   led_pattern_monitor #(.NB_LEDS(4), .NB_COUNT(4), .LOCK_LEN(LOCK_LEN)) dutSmall (
      .clock(clock), .i_reset(sReset), .i_valid(sValid), .i_led(sLed),
      .o_locked(sLocked), .o_direction(sDir), .o_dir_change(sDirChange),
      .o_error(sError), .o_step_count(sSteps), .o_err_count(sErrs)
   );

   always #5 clock = ~clock;

   // Reference model: tracks codes as positions 0/1/2 on a ring; a step of +1
   // around the ring is forward, +2 is reverse.
   bit        refHasPrev;
   int        refPrev;
   int        refRun;
   bit        refDir;
   bit        refDirChange;
   bit        refError;
   int        refSteps;
   int        refErrs;

   function automatic int codeIndex(logic [3:0] code);
      if (code == CA) return 0;
      if (code == CB) return 1;
      if (code == CC) return 2;
      return -1;
   endfunction

   task automatic modelStep(input logic r, input logic v, input logic [3:0] led);
      int ci;
      int diff;
      bit newDir;
      refDirChange = 0;
      refError     = 0;
      if (r) begin
         refHasPrev = 0; refPrev = 0; refRun = 0; refDir = 0;
         refSteps = 0; refErrs = 0;
         return;
      end
      if (!v) return;
      ci = codeIndex(led);
      if (ci < 0) begin
         refError = 1;
         refErrs = (refErrs < 65535) ? refErrs + 1 : 65535;
         refRun = 0;
         refHasPrev = 0;
      end else if (!refHasPrev) begin
         refHasPrev = 1;
         refPrev = ci;
      end else if (ci == refPrev) begin
         refError = 1;
         refErrs = (refErrs < 65535) ? refErrs + 1 : 65535;
         refRun = 0;
      end else begin
         diff = (ci - refPrev + 3) % 3;
         newDir = (diff == 2);
         if (refRun >= LOCK_LEN && newDir != refDir) refDirChange = 1;
         refDir = newDir;
         refSteps = (refSteps + 1) % 65536;
         refRun = (refRun + 1 > LOCK_LEN) ? LOCK_LEN : refRun + 1;
         refPrev = ci;
      end
   endtask

   task automatic compareField(input string name, input string field, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("[TB] FAIL %s %s: got %0d, expected %0d", name, field, act, exp);
   endtask

   // Drive one sample on the main instance and wait until its result is visible.
   task automatic applyStimulus(input logic r, input logic v, input logic [3:0] led);
      mReset = r; mValid = v; mLed = led;
      modelStep(r, v, led);
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic checkOutput(input string name, input bit eLocked, input bit eDir,
                              input bit eDchg, input bit eErr, input int eSteps, input int eErrs);
      compareField(name, "locked", int'(mLocked), int'(eLocked));
      compareField(name, "direction", int'(mDir), int'(eDir));
      compareField(name, "dir_change", int'(mDirChange), int'(eDchg));
      compareField(name, "error", int'(mError), int'(eErr));
      compareField(name, "step_count", int'(mSteps), eSteps);
      compareField(name, "err_count", int'(mErrs), eErrs);
   endtask

   task automatic applySmall(input logic r, input logic v, input logic [3:0] led);
      sReset = r; sValid = v; sLed = led;
      @(posedge clock);
      @(negedge clock);
   endtask

   typedef struct {
      logic       rst;
      logic       val;
      logic [3:0] led;
      bit         eLocked;
      bit         eDir;
      bit         eDchg;
      bit         eErr;
      int         eSteps;
      int         eErrs;
   } Vector;

   Vector vecs[$];

   initial begin
      logic [3:0] ring [3];
      bit r;
      bit v;
      logic [3:0] led;

      // Directed vectors: rst, valid, led | locked, dir, dir_change, error, steps, errs
      vecs.push_back('{1'b1, 1'b0, CA, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{1'b0, 1'b1, CA, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{1'b0, 1'b1, CB, 0, 0, 0, 0, 1, 0});
      vecs.push_back('{1'b0, 1'b1, CC, 0, 0, 0, 0, 2, 0});
      vecs.push_back('{1'b0, 1'b1, CA, 1, 0, 0, 0, 3, 0});
      vecs.push_back('{1'b0, 1'b1, CB, 1, 0, 0, 0, 4, 0});
      vecs.push_back('{1'b0, 1'b1, CA, 1, 1, 1, 0, 5, 0});
      vecs.push_back('{1'b0, 1'b0, CB, 1, 1, 0, 0, 5, 0});
      vecs.push_back('{1'b0, 1'b1, CF, 0, 1, 0, 1, 5, 1});
      vecs.push_back('{1'b0, 1'b1, CA, 0, 1, 0, 0, 5, 1});
      vecs.push_back('{1'b0, 1'b1, CC, 0, 1, 0, 0, 6, 1});
      vecs.push_back('{1'b0, 1'b1, CB, 0, 1, 0, 0, 7, 1});
      vecs.push_back('{1'b0, 1'b1, CA, 1, 1, 0, 0, 8, 1});
      vecs.push_back('{1'b1, 1'b0, CA, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{1'b0, 1'b1, CA, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{1'b0, 1'b1, CA, 0, 0, 0, 1, 0, 1});
      vecs.push_back('{1'b0, 1'b1, CB, 0, 0, 0, 0, 1, 1});
      vecs.push_back('{1'b0, 1'b1, CC, 0, 0, 0, 0, 2, 1});
      vecs.push_back('{1'b0, 1'b1, CA, 1, 0, 0, 0, 3, 1});
      vecs.push_back('{1'b0, 1'b1, CA, 0, 0, 0, 1, 3, 2});
      vecs.push_back('{1'b0, 1'b1, CB, 0, 0, 0, 0, 4, 2});
      vecs.push_back('{1'b0, 1'b1, CC, 0, 0, 0, 0, 5, 2});
      vecs.push_back('{1'b0, 1'b1, CA, 1, 0, 0, 0, 6, 2});
      vecs.push_back('{1'b1, 1'b1, CB, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{1'b0, 1'b0, CB, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{1'b0, 1'b1, CB, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{1'b0, 1'b0, CF, 0, 0, 0, 0, 0, 0});
      vecs.push_back('{1'b0, 1'b1, CA, 0, 1, 0, 0, 1, 0});
      vecs.push_back('{1'b0, 1'b1, CF, 0, 1, 0, 1, 1, 1});
      vecs.push_back('{1'b0, 1'b1, 4'b0101, 0, 1, 0, 1, 1, 2});

      @(negedge clock);
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].val, vecs[i].led);
         checkOutput($sformatf("vec%0d", i), vecs[i].eLocked, vecs[i].eDir,
                     vecs[i].eDchg, vecs[i].eErr, vecs[i].eSteps, vecs[i].eErrs);
      end
      mValid = 1'b0;

      // Narrow counters: 17 forward steps wrap the step count, 17 errors saturate.
      ring[0] = CA; ring[1] = CB; ring[2] = CC;
      applySmall(1'b1, 1'b0, CA);
      applySmall(1'b0, 1'b1, CA);
      for (int i = 1; i <= 17; i++) begin
         applySmall(1'b0, 1'b1, ring[i % 3]);
         if (i == 15) compareField("small15", "step_count", int'(sSteps), 15);
         if (i == 16) compareField("small16", "step_count", int'(sSteps), 0);
      end
      compareField("small17", "step_count", int'(sSteps), 1);
      compareField("small17", "locked", int'(sLocked), 1);
      for (int i = 1; i <= 17; i++) begin
         applySmall(1'b0, 1'b1, CF);
         if (i == 14) compareField("smallErr14", "err_count", int'(sErrs), 14);
      end
      compareField("smallErr17", "err_count", int'(sErrs), 15);
      compareField("smallErr17", "step_count", int'(sSteps), 1);
      compareField("smallErr17", "error", int'(sError), 1);
      compareField("smallErr17", "locked", int'(sLocked), 0);
      sValid = 1'b0;

      // Random traffic checked against the reference model.
      applyStimulus(1'b1, 1'b0, CA);
      checkOutput("rndReset", 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 600; i++) begin
         r = ($urandom_range(0, 99) < 2);
         v = ($urandom_range(0, 99) < 75);
         if ($urandom_range(0, 99) < 85) led = ring[$urandom_range(0, 2)];
         else led = 4'($urandom_range(0, 15));
         applyStimulus(r, v, led);
         checkOutput($sformatf("rnd%0d", i), refRun >= LOCK_LEN, refDir,
                     refDirChange, refError, refSteps, refErrs);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
